button_debounce_array: RTL and testbench
========================================

// Module: button_debounce_array
// PURPOSE
//  N-channel debouncer/edge-event generator for board push-buttons; successor to the single-event debouncer.
//  Per channel: 2-FF synchroniser, bounce-rejecting FSM, clean level, 1-cycle press/release/long-press pulses.
//  Sits between board button pins and game-control logic (cursor move, reveal, flag).
// PARAMETERS
//  N_BTN        5           number of independent button channels
//  DEBOUNCE_CYC 1_000_000   cycles input must stay stable to accept a press or release (>=2)
//  LONG_CYC     50_000_000  cycles in HELD before long_o fires (>DEBOUNCE_CYC)
//  REPEAT_CYC   10_000_000  auto-repeat period after long press (BTN_AUTOREPEAT_EN only, >=2)
// PORTS
//  clk        in   1      system clock
//  rst_n      in   1      reset, synchronous, active-low
//  btn_raw_i  in   N_BTN  asynchronous raw button inputs, 1 = pressed
//  btn_lvl_o  out  N_BTN  debounced level, 1 = accepted pressed
//  press_o    out  N_BTN  1-cycle pulse on accepted press (also auto-repeat pulses)
//  release_o  out  N_BTN  1-cycle pulse on accepted release
//  long_o     out  N_BTN  1-cycle pulse when held LONG_CYC cycles past press acceptance
// BEHAVIOUR
//  - Reset: all outputs 0; sync flops 0; every FSM IDLE; all counters 0. Reset mid-operation aborts all channels
//    silently (no release_o). A button held through reset is re-debounced and yields press_o after reset.
//  - Channels fully independent; any combination of bits may pulse in the same cycle.
//  - s = 2-FF synchronised raw input. Debounce counter dcnt, hold counter hcnt per channel.
//  - FSM: IDLE: s=1 -> PRESS_WAIT, dcnt=0.
//    PRESS_WAIT: s=0 -> IDLE (bounce, no event); dcnt==DEBOUNCE_CYC-1 & s=1 -> HELD, press_o, lvl=1, hcnt=0; else dcnt++.
//    HELD: s=1 -> hcnt++ (saturates at LONG_CYC-1, no wrap); long_o on the clock hcnt reaches LONG_CYC-1 (once per press).
//          s=0 -> REL_WAIT, dcnt=0.
//    REL_WAIT: s=1 -> HELD (release glitch, hcnt kept, no event); dcnt==DEBOUNCE_CYC-1 & s=0 -> IDLE, release_o, lvl=0.
//  - Pulses/level registered; latency from first clk edge sampling raw=1 (clean) to press_o high = DEBOUNCE_CYC+3.
//    Same latency raw 1->0 to release_o. long_o high exactly LONG_CYC cycles after press_o.
//  - press_o and release_o never both high on one channel in one cycle; press/release strictly alternate.
//  - Counter width CNT_W = $clog2(max(DEBOUNCE_CYC, LONG_CYC, REPEAT_CYC)+1).
// CONFIGURATION
//  - Macro BTN_AUTOREPEAT_EN defined: in HELD after long_o, press_o re-pulses every REPEAT_CYC cycles
//    (first repeat REPEAT_CYC cycles after long_o) until leaving HELD; repeat counter resets on REL_WAIT->HELD.
//  - Not defined: no repeat logic synthesised; press_o fires once per accepted press; REPEAT_CYC ignored.
// STRUCTURE
//  - Package btn_pkg: typedef enum btn_state_t {IDLE, PRESS_WAIT, HELD, REL_WAIT}; function cnt_width().
//  - Sub-module btn_channel: one channel (sync, FSM, counters, pulses); top generates N_BTN instances.
//  - Top holds parameter sanity checks (elaboration $error on DEBOUNCE_CYC<2 or LONG_CYC<=DEBOUNCE_CYC).
// TESTING (bench params N_BTN=5, DEBOUNCE_CYC=4, LONG_CYC=20, REPEAT_CYC=8)
//  - Clean press ch0 held 10 cycles -> press_o[0] 1 cycle, 7 cycles after raw rise; lvl[0]=1; no long_o.
//  - Bounce ch1: raw 1,0,1,0 every 2 cycles then steady 1 -> exactly one press_o[1], 7 cycles after last rise.
//  - Hold ch2 40 cycles -> long_o[2] 20 cycles after press_o[2]; release -> release_o[2] 7 cycles after raw fall.
//  - 2-cycle release glitch during hold ch3 -> no release_o, no second press_o, long_o timing unchanged.
//  - Simultaneous press ch0+ch4 -> press_o=5'b10001 in one cycle; rst_n low mid-hold -> all outputs 0 next cycle.
//  - BTN_AUTOREPEAT_EN, hold ch0 60 cycles -> press_o[0] at +0, long_o at +20, repeats at +28,+36,+44,+52.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared types and helpers for the push-button debouncer array.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        REL_WAIT
    } btn_state_t;

    // Counter width large enough to hold the longest of the three periods.
    function automatic int cnt_width(input int debCyc, input int longCyc, input int repCyc);
        int maxCyc;
        maxCyc = debCyc;
        if (longCyc > maxCyc) maxCyc = longCyc;
        if (repCyc > maxCyc) maxCyc = repCyc;
        return $clog2(maxCyc + 1);
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-FF synchroniser, bounce-rejecting FSM, hold counter and event pulses.
// Auto-repeat of press_o after a long press is built only when BTN_AUTOREPEAT_EN is defined.
module btn_channel
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 4,
    parameter int LONG_CYC     = 20,
`ifdef BTN_AUTOREPEAT_EN
    parameter int REPEAT_CYC   = 8,
`endif
    parameter int CNT_W        = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw_i,
    output logic btn_lvl_o,
    output logic press_o,
    output logic release_o,
    output logic long_o
);

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
`ifdef BTN_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYC - 1);
`endif

    logic [1:0]       sync_q;
    logic             s;
    btn_state_t       state_q, state_d;
    logic [CNT_W-1:0] dcnt_q, dcnt_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic             longDone_q, longDone_d;
    logic             lvl_q, lvl_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             long_q, long_d;
`ifdef BTN_AUTOREPEAT_EN
    logic [CNT_W-1:0] rcnt_q, rcnt_d;
`endif

    assign s = sync_q[1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q     <= '0;
            state_q    <= IDLE;
            dcnt_q     <= '0;
            hcnt_q     <= '0;
            longDone_q <= 1'b0;
            lvl_q      <= 1'b0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            long_q     <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
            rcnt_q     <= '0;
`endif
        end else begin
            sync_q     <= {sync_q[0], btn_raw_i};
            state_q    <= state_d;
            dcnt_q     <= dcnt_d;
            hcnt_q     <= hcnt_d;
            longDone_q <= longDone_d;
            lvl_q      <= lvl_d;
            press_q    <= press_d;
            release_q  <= release_d;
            long_q     <= long_d;
`ifdef BTN_AUTOREPEAT_EN
            rcnt_q     <= rcnt_d;
`endif
        end
    end

    // hcnt keeps running through a release glitch so long-press timing is not disturbed.
    always_comb begin
        state_d    = state_q;
        dcnt_d     = dcnt_q;
        hcnt_d     = hcnt_q;
        longDone_d = longDone_q;
        lvl_d      = lvl_q;
        press_d    = 1'b0;
        release_d  = 1'b0;
        long_d     = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
        rcnt_d     = rcnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (s) begin
                    state_d = PRESS_WAIT;
                    dcnt_d  = '0;
                end
            end
            PRESS_WAIT: begin
                if (!s) begin
                    state_d = IDLE;
                end else if (dcnt_q == DEB_LAST) begin
                    state_d    = HELD;
                    press_d    = 1'b1;
                    lvl_d      = 1'b1;
                    hcnt_d     = '0;
                    longDone_d = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
                    rcnt_d     = '0;
`endif
                end else begin
                    dcnt_d = dcnt_q + CNT_ONE;
                end
            end
            HELD: begin
                if (hcnt_q != LONG_LAST) hcnt_d = hcnt_q + CNT_ONE;
                if (hcnt_q == LONG_LAST && !longDone_q) begin
                    long_d     = 1'b1;
                    longDone_d = 1'b1;
                end
`ifdef BTN_AUTOREPEAT_EN
                if (longDone_q) begin
                    if (rcnt_q == REP_LAST) begin
                        press_d = 1'b1;
                        rcnt_d  = '0;
                    end else begin
                        rcnt_d = rcnt_q + CNT_ONE;
                    end
                end
`endif
                if (!s) begin
                    state_d = REL_WAIT;
                    dcnt_d  = '0;
                end
            end
            REL_WAIT: begin
                if (hcnt_q != LONG_LAST) hcnt_d = hcnt_q + CNT_ONE;
                if (s) begin
                    state_d = HELD;
`ifdef BTN_AUTOREPEAT_EN
                    rcnt_d  = '0;
`endif
                end else if (dcnt_q == DEB_LAST) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                    lvl_d     = 1'b0;
                end else begin
                    dcnt_d = dcnt_q + CNT_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign btn_lvl_o = lvl_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign long_o    = long_q;

endmodule

// File: rtl/button_debounce_array.sv
// N independent debounced push-button channels with press/release/long-press pulses.
// Define BTN_AUTOREPEAT_EN to make press_o auto-repeat every REPEAT_CYC cycles after a long press.
module button_debounce_array
    import btn_pkg::*;
#(
    parameter int N_BTN        = 5,
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int LONG_CYC     = 50_000_000,
    parameter int REPEAT_CYC   = 10_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_raw_i,
    output logic [N_BTN-1:0] btn_lvl_o,
    output logic [N_BTN-1:0] press_o,
    output logic [N_BTN-1:0] release_o,
    output logic [N_BTN-1:0] long_o
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYC, LONG_CYC, REPEAT_CYC);

    if (DEBOUNCE_CYC < 2) begin : g_bad_debounce
        $error("button_debounce_array: DEBOUNCE_CYC must be >= 2");
    end
    if (LONG_CYC <= DEBOUNCE_CYC) begin : g_bad_long
        $error("button_debounce_array: LONG_CYC must exceed DEBOUNCE_CYC");
    end
`ifdef BTN_AUTOREPEAT_EN
    if (REPEAT_CYC < 2) begin : g_bad_repeat
        $error("button_debounce_array: REPEAT_CYC must be >= 2");
    end
`endif

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        btn_channel #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC),
            .LONG_CYC     (LONG_CYC),
`ifdef BTN_AUTOREPEAT_EN
            .REPEAT_CYC   (REPEAT_CYC),
`endif
            .CNT_W        (CNT_W)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .btn_raw_i (btn_raw_i[i]),
            .btn_lvl_o (btn_lvl_o[i]),
            .press_o   (press_o[i]),
            .release_o (release_o[i]),
            .long_o    (long_o[i])
        );
    end

endmodule

// File: tb/tb_button_debounce_array.sv
// Directed bench for button_debounce_array (N_BTN=5, DEBOUNCE_CYC=4, LONG_CYC=20, REPEAT_CYC=8).
// Repeat expectations follow BTN_AUTOREPEAT_EN when it is defined for the build.
module tb_button_debounce_array;

    localparam int N_BTN = 5;

    logic             clk;
    logic             rst_n;
    logic [N_BTN-1:0] btnRaw;
    logic [N_BTN-1:0] btnLvl;
    logic [N_BTN-1:0] press;
    logic [N_BTN-1:0] rel;
    logic [N_BTN-1:0] lng;

    int passCount  = 0;
    int checkCount = 0;

    button_debounce_array #(
        .N_BTN        (N_BTN),
        .DEBOUNCE_CYC (4),
        .LONG_CYC     (20),
        .REPEAT_CYC   (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_raw_i (btnRaw),
        .btn_lvl_o (btnLvl),
        .press_o   (press),
        .release_o (rel),
        .long_o    (lng)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [N_BTN-1:0] raw);
        btnRaw = raw;
    endtask

    task automatic checkOutput(input string tag, input logic [N_BTN-1:0] observed,
                               input logic [N_BTN-1:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
    endtask

    // Watch one channel for n cycles; event offsets count edges since the last input change.
    task automatic watchChannel(input string tag, input int ch, input int first, input int last,
                                input int pressAt, input int releaseAt, input int longAt);
        logic [N_BTN-1:0] m;
        m = N_BTN'(1) << ch;
        for (int k = first; k <= last; k++) begin
            tick();
            checkOutput($sformatf("%s press k=%0d", tag, k), press & m, (k == pressAt) ? m : '0);
            checkOutput($sformatf("%s release k=%0d", tag, k), rel & m, (k == releaseAt) ? m : '0);
            checkOutput($sformatf("%s long k=%0d", tag, k), lng & m, (k == longAt) ? m : '0);
        end
    endtask

    initial begin
        logic [N_BTN-1:0] expPress;
        rst_n = 1'b0;
        applyStimulus('0);
        tick();
        tick();
        checkOutput("reset lvl", btnLvl, '0);
        checkOutput("reset press", press, '0);
        checkOutput("reset release", rel, '0);
        checkOutput("reset long", lng, '0);
        rst_n = 1'b1;
        tick();

        $display("[TB] clean press ch0");
        applyStimulus(5'b00001);
        watchChannel("ch0 clean", 0, 1, 10, 7, -1, -1);
        checkOutput("ch0 lvl held", btnLvl, 5'b00001);
        applyStimulus('0);
        watchChannel("ch0 rel", 0, 1, 9, -1, 7, -1);
        checkOutput("ch0 lvl released", btnLvl, '0);

        $display("[TB] bounce ch1");
        applyStimulus(5'b00010);
        watchChannel("ch1 b1", 1, 1, 2, -1, -1, -1);
        applyStimulus('0);
        watchChannel("ch1 b2", 1, 1, 2, -1, -1, -1);
        applyStimulus(5'b00010);
        watchChannel("ch1 b3", 1, 1, 2, -1, -1, -1);
        applyStimulus('0);
        watchChannel("ch1 b4", 1, 1, 2, -1, -1, -1);
        applyStimulus(5'b00010);
        watchChannel("ch1 steady", 1, 1, 10, 7, -1, -1);
        checkOutput("ch1 lvl", btnLvl, 5'b00010);
        applyStimulus('0);
        watchChannel("ch1 rel", 1, 1, 9, -1, 7, -1);

        $display("[TB] long hold ch2");
        applyStimulus(5'b00100);
        watchChannel("ch2 hold", 2, 1, 40, 7, -1, 27);
        checkOutput("ch2 lvl", btnLvl, 5'b00100);
        applyStimulus('0);
        watchChannel("ch2 rel", 2, 1, 9, -1, 7, -1);
        checkOutput("ch2 lvl released", btnLvl, '0);

        $display("[TB] release glitch ch3");
        applyStimulus(5'b01000);
        watchChannel("ch3 press", 3, 1, 12, 7, -1, -1);
        applyStimulus('0);
        watchChannel("ch3 glitch", 3, 13, 14, -1, -1, -1);
        applyStimulus(5'b01000);
        watchChannel("ch3 hold", 3, 15, 34, -1, -1, 27);
        checkOutput("ch3 lvl", btnLvl, 5'b01000);
        applyStimulus('0);
        watchChannel("ch3 rel", 3, 1, 9, -1, 7, -1);

        $display("[TB] simultaneous ch0+ch4 and mid-hold reset");
        applyStimulus(5'b10001);
        for (int k = 1; k <= 10; k++) begin
            tick();
            checkOutput($sformatf("dual press k=%0d", k), press, (k == 7) ? 5'b10001 : 5'b00000);
        end
        checkOutput("dual lvl", btnLvl, 5'b10001);
        rst_n = 1'b0;
        tick();
        checkOutput("mid reset lvl", btnLvl, '0);
        checkOutput("mid reset press", press, '0);
        checkOutput("mid reset release", rel, '0);
        checkOutput("mid reset long", lng, '0);
        rst_n = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            checkOutput($sformatf("post reset press k=%0d", k), press, (k == 7) ? 5'b10001 : 5'b00000);
            checkOutput($sformatf("post reset release k=%0d", k), rel, '0);
        end
        applyStimulus('0);
        for (int k = 1; k <= 9; k++) begin
            tick();
            checkOutput($sformatf("dual release k=%0d", k), rel, (k == 7) ? 5'b10001 : 5'b00000);
        end

        $display("[TB] long hold ch0 with repeat window");
        applyStimulus(5'b00001);
        for (int k = 1; k <= 64; k++) begin
            tick();
            expPress = (k == 7) ? 5'b00001 : 5'b00000;
`ifdef BTN_AUTOREPEAT_EN
            if (k == 35 || k == 43 || k == 51 || k == 59) expPress = 5'b00001;
`endif
            checkOutput($sformatf("ch0 repeat press k=%0d", k), press, expPress);
            checkOutput($sformatf("ch0 repeat long k=%0d", k), lng, (k == 27) ? 5'b00001 : 5'b00000);
        end
        applyStimulus('0);
        watchChannel("ch0 long rel", 0, 1, 9, -1, 7, -1);
        checkOutput("final lvl", btnLvl, '0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
